flash_read_sequencer: RTL and testbench
=======================================

Name: flash_read_sequencer

Overview:
- Sequences 32-bit word reads from the external flash (Avalon-MM read master) and emits one 16-bit audio sample per sample tick.
- Driven by the keyboard control FSM through three inputs:
  - start_read: play or pause.
  - dir: 0 is forward, 1 is backward.
  - restart: jump to the start of playback in the current direction.
- Returns the read_finish pulse, which tells the control FSM it may change state between words.

Parameters:
- ADDR_W, 23: flash word-address width.
- LAST_ADDR, 23'h7FFFF: last word address of the sample region.
- DATA_W, 32: flash read-data width; always two samples per word.
- TIMEOUT_CYC, 255: watchdog limit in clk cycles (used only with FLASH_TIMEOUT_EN).

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start_read, in, 1: playback enable.
- dir, in, 1: 0 forward, 1 backward.
- restart, in, 1: level; reposition at the next word boundary.
- sample_tick, in, 1: one-cycle pulse at the audio sample rate, already synchronised to clk.
- flash_address, out, ADDR_W: word address.
- flash_read, out, 1: Avalon read request.
- flash_waitrequest, in, 1: slave stall.
- flash_readdata, in, DATA_W: read data.
- flash_readdatavalid, in, 1: read data valid.
- audio_sample, out, 16: current sample, held between updates.
- sample_valid, out, 1: one-cycle pulse whenever audio_sample updates.
- read_finish, out, 1: one-cycle pulse after a word's two samples are emitted.
- timeout_err, out, 1: sticky error flag; tied 0 when FLASH_TIMEOUT_EN is undefined.

Behaviour:
- Reset values: state IDLE; flash_address 0; flash_read 0; audio_sample 0; sample_valid 0; read_finish 0; timeout_err 0; word register 0.
- IDLE:
  - If start_read=1 and sample_tick=1, go to REQ.
  - Otherwise stay. A tick while start_read=0 is ignored; this is pause.
- REQ:
  - flash_read=1 with flash_address held stable.
  - Leave for WAIT_DATA in the first cycle where flash_waitrequest=0.
- WAIT_DATA:
  - flash_read=0.
  - On flash_readdatavalid=1, capture flash_readdata and go to EMIT1.
- EMIT1 (one cycle):
  - audio_sample = readdata[15:0] if dir=0, else readdata[31:16].
  - sample_valid=1. Go to HOLD.
- HOLD: wait for sample_tick, then go to EMIT2. start_read=0 does not abort HOLD; the second sample is always emitted.
- EMIT2 (one cycle):
  - Emit the other half-word.
  - sample_valid=1. Go to ADVANCE.
- ADVANCE (one cycle):
  - read_finish=1.
  - If restart=1: flash_address = 0 (dir=0) or LAST_ADDR (dir=1).
  - Otherwise step the address: forward +1, wrapping LAST_ADDR to 0; backward -1, wrapping 0 to LAST_ADDR.
  - Go to IDLE.
- Sampling of dir and restart:
  - dir is sampled only at EMIT1, EMIT2 and ADVANCE.
  - A dir change mid-word takes effect for half-word ordering on the next word.
  - restart is sampled only in ADVANCE; restart asserted elsewhere has no effect.
- Latency: tick to first sample is 2 + waitrequest cycles + readdatavalid latency + 1.
- Sample ticks while in REQ or WAIT_DATA are dropped and not queued.
- Simultaneous tick and readdatavalid in WAIT_DATA: take the data; the tick is dropped.
- rst_n low in any state:
  - Immediately returns to IDLE with all outputs at reset values.
  - An outstanding flash read is abandoned; its late readdatavalid is ignored in IDLE.

Optional Feature:
- Macro: FLASH_TIMEOUT_EN.
- When defined:
  - An 8-bit counter runs in REQ and WAIT_DATA and clears on entry to either state.
  - If it reaches TIMEOUT_CYC: flash_read drops to 0, audio_sample is forced to 0, sample_valid pulses, timeout_err sets (sticky until rst_n), then go to ADVANCE. Playback continues at the next word.
- When undefined: no counter; REQ and WAIT_DATA wait indefinitely; timeout_err is tied 0.

Decomposition:
- Package flash_seq_pkg:
  - state_t enum {IDLE, REQ, WAIT_DATA, EMIT1, HOLD, EMIT2, ADVANCE}.
  - ADDR_W and LAST_ADDR defaults.
  - Direction constants DIR_FWD=1'b0, DIR_BWD=1'b1.
- Sub-module flash_addr_counter:
  - Up/down wrapping counter with synchronous load of 0 or LAST_ADDR.
  - Inputs: step, dir, load.
  - Async active-low reset to 0.

Test Plan:
- Forward readout:
  - Stimulus: dir=0, start_read=1, address 0; slave returns 32'hAAAA_5555 with waitrequest for 2 cycles and readdatavalid 3 cycles after the request.
  - Response: samples 16'h5555 then 16'hAAAA on consecutive ticks; read_finish pulses once; flash_address becomes 1.
- Backward wrap:
  - Stimulus: dir=1, address 0, one word played.
  - Response: order is high half then low half; flash_address becomes 23'h7FFFF. A forward word at 23'h7FFFF wraps the address to 0.
- Restart:
  - Stimulus: at address 23'h00123, hold restart=1 through ADVANCE with dir=0; repeat with dir=1.
  - Response: next address 0 (dir=0), or LAST_ADDR (dir=1).
- Pause:
  - Stimulus: deassert start_read during HOLD.
  - Response: the second sample is still emitted and read_finish still pulses; then no flash_read occurs for 10 ticks; reasserting start_read resumes at the next address.
- Async reset mid-read:
  - Stimulus: drop rst_n in WAIT_DATA; a late readdatavalid arrives after reset.
  - Response: all outputs are 0 and the late data is ignored.
- Timeout (FLASH_TIMEOUT_EN defined):
  - Stimulus: no readdatavalid for 255 cycles.
  - Response: audio_sample=0, timeout_err=1, read_finish pulses, address advances by 1.

Source files
------------

// File: rtl/flash_seq_pkg.sv
// Shared types and default sizes for the flash read sequencer.
// Imported by the bus interface, the address counter and the sequencer top.
package flash_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT1,
    HOLD,
    EMIT2,
    ADVANCE
  } state_t;

  localparam int               FLASH_ADDR_W      = 23;
  localparam logic [22:0]      FLASH_LAST_ADDR   = 23'h7FFFF;
  localparam int               FLASH_DATA_W      = 32;
  localparam int               FLASH_TIMEOUT_CYC = 255;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

endpackage

// File: rtl/flash_read_sequencer_if.sv
// Avalon-MM read-master bundle between the sequencer (master) and the flash slave.
interface flash_read_sequencer_if
  import flash_seq_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W
);
  logic [ADDR_W-1:0] flash_address;
  logic              flash_read;
  logic              flash_waitrequest;
  logic [DATA_W-1:0] flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    output flash_address,
    output flash_read,
    input  flash_waitrequest,
    input  flash_readdata,
    input  flash_readdatavalid
  );

  modport slave (
    input  flash_address,
    input  flash_read,
    output flash_waitrequest,
    output flash_readdata,
    output flash_readdatavalid
  );
endinterface

// File: rtl/flash_addr_counter.sv
// Wrapping up/down word-address counter with a synchronous load of the
// playback start point (0 going forward, LAST_ADDR going backward).
module flash_addr_counter
  import flash_seq_pkg::*;
#(
  parameter int                ADDR_W    = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FLASH_LAST_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_i,
  input  logic              dir_i,
  input  logic              load_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = (dir_i == DIR_FWD) ? '0 : LAST_ADDR;
    end else if (step_i) begin
      if (dir_i == DIR_FWD) begin
        addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == '0) ? LAST_ADDR : addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/flash_read_sequencer.sv
// Reads one 32-bit flash word per two sample ticks and plays its half-words out.
// Optional watchdog on stalled reads is enabled by defining FLASH_TIMEOUT_EN.
module flash_read_sequencer
  import flash_seq_pkg::*;
#(
  parameter int                ADDR_W    = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FLASH_LAST_ADDR),
  parameter int                DATA_W    = FLASH_DATA_W
`ifdef FLASH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = FLASH_TIMEOUT_CYC
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_read,
  input  logic                          dir,
  input  logic                          restart,
  input  logic                          sample_tick,
  flash_read_sequencer_if.master        flash,
  output logic [15:0]                   audio_sample,
  output logic                          sample_valid,
  output logic                          read_finish,
  output logic                          timeout_err
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [15:0]       audio_q;
  logic              hi_first_q, hi_first_d;
  logic              addr_step, addr_load;
  logic              tmo_hit;
  logic [ADDR_W-1:0] addr;

  flash_addr_counter #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (addr_step),
    .dir_i  (dir),
    .load_i (addr_load),
    .addr_o (addr)
  );

  assign flash.flash_address = addr;

`ifdef FLASH_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       timeout_err_q;
  logic       in_bus_wait;

  assign in_bus_wait = (state_q == REQ) || (state_q == WAIT_DATA);
  assign tmo_hit     = in_bus_wait && (tmo_cnt_q == TMO_LIMIT);

  // Counter restarts on every entry to REQ or WAIT_DATA, so each bus phase gets the full budget.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_d != state_q) && ((state_d == REQ) || (state_d == WAIT_DATA))) begin
      tmo_cnt_d = '0;
    end else if (in_bus_wait) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_q | tmo_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    word_d           = word_q;
    hi_first_d       = hi_first_q;
    flash.flash_read = 1'b0;
    audio_sample     = audio_q;
    sample_valid     = 1'b0;
    read_finish      = 1'b0;
    addr_step        = 1'b0;
    addr_load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_read && sample_tick) state_d = REQ;
      end
      REQ: begin
        flash.flash_read = 1'b1;
        if (!flash.flash_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash.flash_readdatavalid) begin
          word_d  = flash.flash_readdata;
          state_d = EMIT1;
        end
      end
      EMIT1: begin
        hi_first_d   = (dir == DIR_BWD);
        audio_sample = (dir == DIR_BWD) ? word_q[31:16] : word_q[15:0];
        sample_valid = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (sample_tick) state_d = EMIT2;
      end
      // Second half is always the one not yet played, even if dir moved mid-word.
      EMIT2: begin
        audio_sample = hi_first_q ? word_q[15:0] : word_q[31:16];
        sample_valid = 1'b1;
        state_d      = ADVANCE;
      end
      ADVANCE: begin
        read_finish = 1'b1;
        addr_load   = restart;
        addr_step   = !restart;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      flash.flash_read = 1'b0;
      audio_sample     = '0;
      sample_valid     = 1'b1;
      state_d          = ADVANCE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      audio_q    <= '0;
      hi_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      audio_q    <= audio_sample;
      hi_first_q <= hi_first_d;
    end
  end
endmodule

// File: tb/tb_flash_read_sequencer.sv
// Directed-plus-random bench for flash_read_sequencer with an Avalon slave model
// and a word-level playback model. Timeout steps run when FLASH_TIMEOUT_EN is defined.
module tb_flash_read_sequencer;
  localparam int LAST = 'h7FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_read = 1'b0;
  logic        dir = 1'b0;
  logic        restart = 1'b0;
  logic        sample_tick = 1'b0;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        read_finish;
  logic        timeout_err;

  flash_read_sequencer_if bus ();

  flash_read_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_read   (start_read),
    .dir          (dir),
    .restart      (restart),
    .sample_tick  (sample_tick),
    .flash        (bus),
    .audio_sample (audio_sample),
    .sample_valid (sample_valid),
    .read_finish  (read_finish),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // slave configuration and observation
  int          cfg_wait = 0;
  int          cfg_lat = 1;
  logic [31:0] next_data = '0;
  int          acc_cnt = 0;
  int          acc_addr = 0;

  // monitor observations
  int          sv_cnt = 0;
  int          rf_cnt = 0;
  int          rd_cycles = 0;
  logic [15:0] last_sample = '0;

  int m_addr = 0;

  initial begin : slave
    int          wr_left;
    int          pend_cnt;
    logic [31:0] pend_data;
    logic        in_req;
    wr_left = 0; pend_cnt = 0; pend_data = '0; in_req = 1'b0;
    bus.flash_waitrequest   = 1'b0;
    bus.flash_readdata      = '0;
    bus.flash_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      bus.flash_readdatavalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.flash_readdatavalid = 1'b1;
          bus.flash_readdata      = pend_data;
        end
      end
      if (bus.flash_read) begin
        if (!in_req) begin
          in_req  = 1'b1;
          wr_left = cfg_wait;
        end
        if (wr_left > 0) begin
          bus.flash_waitrequest = 1'b1;
          wr_left--;
        end else begin
          bus.flash_waitrequest = 1'b0;
          in_req   = 1'b0;
          acc_addr = int'(bus.flash_address);
          acc_cnt++;
          if (cfg_lat > 0) begin
            pend_cnt  = cfg_lat;
            pend_data = next_data;
          end
        end
      end else begin
        in_req = 1'b0;
        bus.flash_waitrequest = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        sv_cnt++;
        last_sample = audio_sample;
      end
      if (read_finish) rf_cnt++;
      if (bus.flash_read) rd_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int next_addr(input int a, input logic d, input logic rs);
    if (rs) return d ? LAST : 0;
    if (!d) return (a + 1) % (LAST + 1);
    return (a + LAST) % (LAST + 1);
  endfunction

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_samples(input int n, input int limit);
    int k = 0;
    while (sv_cnt < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("sample_wait", 32'(sv_cnt >= n), 32'd1);
  endtask

  task automatic wait_rf(input int n);
    int k = 0;
    while (rf_cnt < n && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("finish_wait", 32'(rf_cnt >= n), 32'd1);
  endtask

  // One word: d1 = dir at first sample, d2 = dir from HOLD onward,
  // rs_hold = restart through ADVANCE, rs_early = restart only before HOLD.
  task automatic play_word(input logic d1, input logic d2, input logic rs_hold,
                           input logic rs_early, input logic pause,
                           input int w, input int l, input logic [31:0] data);
    int n0, r0, a0;
    logic [31:0] dv;
    dv = data;
    cfg_wait = w; cfg_lat = l; next_data = data;
    dir = d1; restart = rs_early; start_read = 1'b1;
    n0 = sv_cnt; r0 = rf_cnt; a0 = acc_cnt;
    tick();
    wait_samples(n0 + 1, 200);
    chk("req_count", 32'(acc_cnt), 32'(a0 + 1));
    chk("req_addr", 32'(acc_addr), 32'(m_addr));
    chk("sample1", {16'h0, last_sample}, {16'h0, d1 ? dv[31:16] : dv[15:0]});
    @(negedge clk);
    dir = d2; restart = rs_hold;
    if (pause) start_read = 1'b0;
    tick();
    wait_samples(n0 + 2, 50);
    chk("sample2", {16'h0, last_sample}, {16'h0, d1 ? dv[15:0] : dv[31:16]});
    wait_rf(r0 + 1);
    @(negedge clk);
    restart = 1'b0;
    m_addr = next_addr(m_addr, d2, rs_hold);
    chk("next_addr", 32'(bus.flash_address), 32'(m_addr));
    chk("finish_once", 32'(rf_cnt), 32'(r0 + 1));
  endtask

  task automatic play_random_fwd();
    play_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), $urandom);
  endtask

  initial begin : stimulus
    int n0, r0, rd0;
    int k;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(bus.flash_address), 32'd0);
    chk("rst_read", 32'(bus.flash_read), 32'd0);
    chk("rst_audio", {16'h0, audio_sample}, 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_finish", 32'(read_finish), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ticks while paused in IDLE are ignored
    repeat (3) begin
      tick();
      @(negedge clk);
    end
    chk("idle_pause_reads", 32'(rd_cycles), 32'd0);
    chk("idle_pause_samples", 32'(sv_cnt), 32'd0);

    // backward from 0 wraps to LAST, then forward from LAST wraps to 0
    play_word(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2, $urandom);
    chk("bwd_wrap", 32'(bus.flash_address), 32'h7FFFF);
    play_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, $urandom);
    chk("fwd_wrap", 32'(bus.flash_address), 32'h0);

    // forward readout of a known word
    play_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 32'hAAAA_5555);
    chk("fwd_last_sample", {16'h0, last_sample}, 32'h0000_AAAA);
    chk("fwd_addr", 32'(bus.flash_address), 32'd1);

    // async reset during WAIT_DATA with a late readdatavalid
    cfg_wait = 0; cfg_lat = 8; next_data = 32'h1234_5678;
    start_read = 1'b1; dir = 1'b0;
    n0 = sv_cnt; r0 = acc_cnt;
    tick();
    k = 0;
    while (acc_cnt == r0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_req", 32'(acc_cnt), 32'(r0 + 1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_read", 32'(bus.flash_read), 32'd0);
    chk("rst_mid_addr", 32'(bus.flash_address), 32'd0);
    chk("rst_mid_audio", {16'h0, audio_sample}, 32'd0);
    chk("rst_mid_valid", 32'(sample_valid), 32'd0);
    chk("rst_mid_finish", 32'(read_finish), 32'd0);
    @(negedge clk);
    @(negedge clk);
    start_read = 1'b0;
    rst_n = 1'b1;
    rd0 = rd_cycles;
    repeat (12) @(negedge clk);
    chk("late_data_samples", 32'(sv_cnt), 32'(n0));
    chk("late_data_audio", {16'h0, audio_sample}, 32'd0);
    chk("late_data_reads", 32'(rd_cycles), 32'(rd0));
    m_addr = 0;

    // dir flips mid-word: order of this word unchanged, address steps backward
    play_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, $urandom);
    chk("dirflip_addr", 32'(bus.flash_address), 32'h7FFFF);
    play_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, $urandom);

    // restart outside ADVANCE has no effect
    play_word(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1, $urandom);
    chk("early_restart", 32'(bus.flash_address), 32'd1);

    // pause during HOLD
    play_word(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, $urandom);
    rd0 = rd_cycles; n0 = sv_cnt;
    repeat (10) begin
      tick();
      @(negedge clk);
    end
    chk("pause_reads", 32'(rd_cycles), 32'(rd0));
    chk("pause_samples", 32'(sv_cnt), 32'(n0));

    // random forward playback up to 0x123, restart forward
    while (m_addr != 'h123) play_random_fwd();
    play_word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, $urandom);
    chk("restart_fwd", 32'(bus.flash_address), 32'd0);

    while (m_addr != 'h123) play_random_fwd();
    play_word(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, $urandom);
    chk("restart_bwd", 32'(bus.flash_address), 32'h7FFFF);

`ifdef FLASH_TIMEOUT_EN
    // stalled read: watchdog forces a zero sample and moves on
    cfg_wait = 0; cfg_lat = 0;
    start_read = 1'b1; dir = 1'b0; restart = 1'b0;
    n0 = sv_cnt; r0 = rf_cnt;
    tick();
    wait_samples(n0 + 1, 600);
    chk("tmo_sample", {16'h0, last_sample}, 32'd0);
    chk("tmo_err", 32'(timeout_err), 32'd1);
    wait_rf(r0 + 1);
    @(negedge clk);
    m_addr = next_addr(m_addr, 1'b0, 1'b0);
    chk("tmo_addr", 32'(bus.flash_address), 32'(m_addr));
    chk("tmo_one_sample", 32'(sv_cnt), 32'(n0 + 1));
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    chk("tmo_tied", 32'(timeout_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
